pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_fwd_unit.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states,
// forwarding selects and the stall/flush control bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_BUBBLE   = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE = '0;

  // x0 is hardwired zero, so a write to it never produces a hazard.
  function automatic logic reg_hit(
    input logic       en,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// EX/MEM results take precedence over older MEM/WB results.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_hit(mem_reg_write, mem_rd, rs);
  assign wb_hit  = reg_hit(wb_reg_write, wb_rd, rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_mem_wb,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0]  hz_state
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  hz_state_t        state;
  hz_state_t        state_next;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             memwait;
  logic             loaduse;
  logic             loaduse_go;
  logic             redirect_go;

  assign memwait = mem_req & ~mem_ready;

  assign loaduse = ex_mem_read & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (ex_rd == id_rs1)) |
                    (id_use_rs2 & (ex_rd == id_rs2)));

  // In BUBBLE the dependent instruction already got its one bubble.
  assign redirect_go = ex_redirect & ~memwait;
  assign loaduse_go  = loaduse & ~memwait & ~ex_redirect &
                       (state != HZ_BUBBLE);

  always_comb begin
    ctrl = CTRL_IDLE;
    if (memwait) begin
      ctrl.stall_pc     = 1'b1;
      ctrl.stall_if_id  = 1'b1;
      ctrl.stall_id_ex  = 1'b1;
      ctrl.stall_ex_mem = 1'b1;
      ctrl.flush_mem_wb = 1'b1;
    end else if (redirect_go) begin
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
    end else if (loaduse_go) begin
      ctrl.stall_pc     = 1'b1;
      ctrl.stall_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HZ_RUN: begin
        if (memwait) begin
          state_next = HZ_MEM_WAIT;
        end else if (loaduse_go) begin
          state_next = HZ_BUBBLE;
        end
      end
      HZ_BUBBLE: begin
        state_next = memwait ? HZ_MEM_WAIT : HZ_RUN;
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          state_next = HZ_RUN;
        end
      end
      default: state_next = HZ_RUN;
    endcase
  end

  assign cnt_inc = (cnt == TIMEOUT) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HZ_RUN;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == HZ_MEM_WAIT) && (state_next == HZ_MEM_WAIT)) begin
        cnt <= cnt_inc;
        if (cnt_inc == TIMEOUT) begin
          mem_err <= 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (ctrl.stall_pc) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (ctrl.flush_if_id) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  assign stall_pc     = ctrl.stall_pc;
  assign stall_if_id  = ctrl.stall_if_id;
  assign stall_id_ex  = ctrl.stall_id_ex;
  assign stall_ex_mem = ctrl.stall_ex_mem;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_mem_wb = ctrl.flush_mem_wb;
  assign hz_state     = state;

  hazard_fwd_unit u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Control vector order: stall pc/if_id/id_ex/ex_mem, flush if_id/id_ex/mem_wb.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex, flush_mem_wb;
  logic [1:0]  fwd_a, fwd_b, hz_state;
  logic        mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_redirect   (ex_redirect),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .stall_id_ex   (stall_id_ex),
    .stall_ex_mem  (stall_ex_mem),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_mem_wb  (flush_mem_wb),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_err       (mem_err),
`ifdef HAZ_PERF_CNT_EN
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .hz_state      (hz_state)
  );

  wire [6:0] ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                    flush_if_id, flush_id_ex, flush_mem_wb};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
    ex_redirect = 0; mem_rd = 0; mem_reg_write = 0;
    mem_req = 0; mem_ready = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic set_loaduse();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'h00);
    chk("reset_state", 32'(hz_state), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // load-use on rs1, inputs held two cycles
    tick();
    set_loaduse();
    #1;
    chk("lu_ctl", 32'(ctl), 32'b1100010);
    tick();
    chk("lu_state_bubble", 32'(hz_state), 32'd1);
    chk("lu_one_bubble", 32'(ctl), 32'h00);
    tick();
    chk("lu_state_run", 32'(hz_state), 32'd0);
    idle();
    #1;
    chk("lu_clear_ctl", 32'(ctl), 32'h00);

    // load-use via rs2 only; and ex_rd=x0 never stalls
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
    id_rs1 = 9; id_use_rs1 = 0;
    #1;
    chk("lu_rs2_ctl", 32'(ctl), 32'b1100010);
    ex_rd = 0; id_rs2 = 0;
    #1;
    chk("lu_x0_ctl", 32'(ctl), 32'h00);
    idle();
    tick();

    // redirect wins over a coincident load-use
    set_loaduse();
    ex_redirect = 1;
    #1;
    chk("redir_ctl", 32'(ctl), 32'b0000110);
    tick();
    chk("redir_state", 32'(hz_state), 32'd0);
    idle();

    // memwait with a held redirect
    mem_req = 1; ex_redirect = 1;
    #1;
    chk("mw_ctl_1", 32'(ctl), 32'b1111001);
    tick();
    chk("mw_state", 32'(hz_state), 32'd2);
    chk("mw_ctl_2", 32'(ctl), 32'b1111001);
    tick();
    chk("mw_ctl_3", 32'(ctl), 32'b1111001);
    tick();
    mem_ready = 1;
    #1;
    chk("mw_release_ctl", 32'(ctl), 32'b0000110);
    chk("mw_release_state", 32'(hz_state), 32'd2);
    tick();
    chk("mw_back_run", 32'(hz_state), 32'd0);
    idle();

    // counter clears on leaving MEM_WAIT: 3 + 3 waits never time out
    mem_req = 1;
    tick(); tick(); tick(); tick();
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick(); tick(); tick(); tick();
    chk("cnt_clear_leave", 32'(mem_err), 32'd0);
    mem_ready = 1;
    tick();
    idle();

    // counter clears on reset mid-MEM_WAIT
    mem_req = 1;
    tick(); tick(); tick(); tick();
    reset = 1;
    tick();
    chk("rst_mw_state", 32'(hz_state), 32'd0);
    reset = 0;
    tick(); tick(); tick(); tick();
    chk("cnt_clear_reset", 32'(mem_err), 32'd0);
    mem_ready = 1;
    tick();
    idle();
    tick();

    // timeout: mem_ready low for 6 cycles
    mem_req = 1;
    tick();
    chk("to_enter", 32'(hz_state), 32'd2);
    tick(); tick(); tick();
    chk("to_before", 32'(mem_err), 32'd0);
    tick();
    chk("to_raised", 32'(mem_err), 32'd1);
    tick();
    chk("to_freeze", 32'(ctl), 32'b1111001);
    mem_ready = 1;
    tick();
    chk("to_sticky", 32'(mem_err), 32'd1);
    chk("to_run", 32'(hz_state), 32'd0);
    idle();
    reset = 1;
    tick();
    reset = 0;
    chk("to_reset_err", 32'(mem_err), 32'd0);
    chk("to_reset_state", 32'(hz_state), 32'd0);

    // forwarding
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
    ex_rs1 = 7;
    #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'b10);
    mem_reg_write = 0;
    #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'b01);
    ex_rs2 = 0; mem_rd = 0; mem_reg_write = 1; wb_rd = 0;
    #1;
    chk("fwd_b_x0", 32'(fwd_b), 32'b00);
    ex_rs2 = 9; wb_rd = 9;
    #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'b01);
    ex_rs2 = 3;
    #1;
    chk("fwd_b_none", 32'(fwd_b), 32'b00);
    idle();

`ifdef HAZ_PERF_CNT_EN
    reset = 1;
    tick();
    reset = 0;
    set_loaduse();
    tick();
    idle();
    tick();
    ex_redirect = 1;
    tick();
    idle();
    tick();
    chk("perf_stall", perf_stall_cyc, 32'd1);
    chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
